// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_seq_pkg;

  // Widest operand the magnitude helper can handle.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [MAX_W-1:0] mag;
  } abs_t;

  // value must already be sign-extended to MAX_W when signed_flag is set.
  // The most-negative operand yields 2^(W-1), which still fits in W bits
  // once the caller truncates the magnitude back to the operand width.
  function automatic abs_t abs_u(input logic [MAX_W-1:0] value, input logic signed_flag);
    abs_t r;
    r.sign = signed_flag & value[MAX_W-1];
    r.mag  = r.sign ? (~value + MAX_W'(1)) : value;
    return r;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// DTI stream interface: valid/ready handshake with data and end-of-transfer.
// A transfer happens on every rising clock edge where valid and ready are
// both 1. The producer holds valid and data stable until that transfer;
// ready may depend combinationally on valid.
interface dti_s_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic         eot;
  logic [W-1:0] data;

  modport producer (output valid, output data, output eot, input ready);
  modport consumer (input valid, input data, input eot, output ready);
endinterface

// File: rtl/mul_seq_core.sv
// Datapath of the shift-add multiplier: accumulator, shifted operands,
// iteration counter and final sign correction.
module mul_seq_core #(
  parameter int TDIN0 = 8,
  parameter int TDIN1 = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   step,
  input  logic [TDIN0-1:0]       mag0,
  input  logic [TDIN1-1:0]       mag1,
  input  logic                   neg,
  output logic                   done,
  output logic [TDIN0+TDIN1-1:0] product
);

  localparam int TOUT = TDIN0 + TDIN1;
  localparam int CW   = $clog2(TDIN1 + 1);

  logic [TOUT-1:0]  acc_q, acc_d;
  logic [TOUT-1:0]  m0_q, m0_d;
  logic [TDIN1-1:0] m1_q, m1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;

  // Load operands on start; otherwise retire one multiplier bit per step.
  always_comb begin
    acc_d = acc_q;
    m0_d  = m0_q;
    m1_d  = m1_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    if (start) begin
      acc_d = '0;
      m0_d  = TOUT'(mag0);
      m1_d  = mag1;
      cnt_d = CW'(TDIN1);
      neg_d = neg;
    end else if (step) begin
      if (m1_q[0]) begin
        acc_d = acc_q + m0_q;
      end
      m0_d  = m0_q << 1;
      m1_d  = m1_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Datapath registers, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
    end
  end

  // The step taken while cnt is 1 retires the last multiplier bit.
  assign done    = (cnt_q == CW'(1));
  assign product = neg_q ? (~acc_q + TOUT'(1)) : acc_q;

endmodule

// File: rtl/mul_seq.sv
// Iterative multiplier with DTI stream ports: accepts a pair of operands,
// spends TDIN1 cycles in the shift-add core, then offers the product.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int TDIN0       = 8,
  parameter int TDIN1       = 8,
  parameter bit DIN0_SIGNED = 1'b0,
  parameter bit DIN1_SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  dti_s_if.consumer   din0,
  dti_s_if.consumer   din1,
  dti_s_if.producer   dout,
  output state_e      dbg_state
);

  localparam int TOUT = TDIN0 + TDIN1;

  state_e           state_q, state_d;
  logic [MAX_W-1:0] ext0, ext1;
  abs_t             abs0, abs1;
  logic             in_ready;
  logic             out_valid;
  logic             core_start;
  logic             core_step;
  logic             core_done;
  logic [TOUT-1:0]  core_product;
  logic             unused_bits;

  // Widen operands according to their signedness and take magnitudes.
  always_comb begin
    if (DIN0_SIGNED) ext0 = MAX_W'($signed(din0.data));
    else             ext0 = MAX_W'(din0.data);
    if (DIN1_SIGNED) ext1 = MAX_W'($signed(din1.data));
    else             ext1 = MAX_W'(din1.data);
    abs0 = abs_u(ext0, DIN0_SIGNED);
    abs1 = abs_u(ext1, DIN1_SIGNED);
  end

  // Magnitude bits above the operand width are always zero; eot is not used.
  assign unused_bits = ^{abs0.mag, abs1.mag, din0.eot, din1.eot};

  // Next state and handshake outputs; readies only ever rise in IDLE.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_start = 1'b0;
    core_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = din0.valid & din1.valid;
        if (din0.valid && din1.valid) begin
          core_start = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        core_step = 1'b1;
        if (core_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (dout.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight product immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  mul_seq_core #(
    .TDIN0 (TDIN0),
    .TDIN1 (TDIN1)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .step    (core_step),
    .mag0    (abs0.mag[TDIN0-1:0]),
    .mag1    (abs1.mag[TDIN1-1:0]),
    .neg     (abs0.sign ^ abs1.sign),
    .done    (core_done),
    .product (core_product)
  );

  assign din0.ready = in_ready;
  assign din1.ready = in_ready;
  assign dout.valid = out_valid;
  assign dout.data  = core_product;
  assign dout.eot   = 1'b0;
  assign dbg_state  = state_q;

endmodule
